// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a memory
// handshake, a wait-cycle timeout and sticky trap flags.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TCW            = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  // state    | meaning
  // IDLE     | out of reset, no activity
  // FETCH    | read instruction at PC, PC+4 on completion
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // MEMADR   | rs1 + imm address for lw/sw
  // MEMRD    | load data read, waits on mem_ready
  // MEMWR    | store data write, waits on mem_ready
  // MEMWB    | write loaded data to rd
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | write ALUOut to rd
  // BRANCH   | compare rs1/rs2, take branch on zero
  // TRAP     | halted until reset (illegal opcode or bus timeout)
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR,
    S_MEMWB, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [TCW-1:0] LIMIT  = TCW'(TIMEOUT_CYCLES);
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TCW-1:0] CNT_MAX = '1;

  state_t         state, state_next;
  logic [TCW-1:0] cnt, cnt_next;
  logic           is_mem, timeout, set_illegal, set_bus_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  assign is_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // A ready arriving on the limit cycle still completes the access.
  assign timeout = TO_EN && is_mem && !mem_ready && (cnt == LIMIT);

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_op      = 2'b00;
    imm_sel     = 2'b00;
    halted      = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_sel   = 2'b10;
        case (instr[6:0])
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_REG:            state_next = S_EXECR;
          OP_IMM:            state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          default: begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        // opcode bit 5 separates store from load
        imm_sel    = instr[5] ? 2'b01 : 2'b00;
        state_next = instr[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = alu_zero;
        state_next = S_FETCH;
      end
      S_TRAP: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase

    if (timeout) begin
      state_next  = S_TRAP;
      set_bus_err = 1'b1;
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (state_next != state)
      cnt_next = '0;
    else if (is_mem && mem_ready)
      cnt_next = '0;
    else if (is_mem && (cnt != CNT_MAX))
      cnt_next = cnt + 1'b1;
  end

endmodule
